// File: rtl/load_store_unit_if.sv
// Request/response channel between the multicycle control FSM (master)
// and the load/store unit (slave).
interface load_store_unit_if #(
    parameter int WIDTH = 32
) ();
    logic             req_valid;
    logic             req_ready;
    logic             req_store;
    logic [2:0]       req_funct3;
    logic [WIDTH-1:0] base_addr;
    logic [WIDTH-1:0] offset;
    logic [WIDTH-1:0] store_data;
    logic             done;
    logic             misaligned;
    logic             fault;
    logic [WIDTH-1:0] load_result;

    modport master (
        output req_valid, req_store, req_funct3, base_addr, offset, store_data,
        input  req_ready, done, misaligned, fault, load_result
    );

    modport slave (
        input  req_valid, req_store, req_funct3, base_addr, offset, store_data,
        output req_ready, done, misaligned, fault, load_result
    );
endinterface

// File: rtl/load_store_unit.sv
// Data-memory initiator: computes the effective address, validates size,
// alignment and range, sequences one DataMemory access and returns load data.
module load_store_unit #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 12
) (
    input  logic             clk,
    input  logic             rst,
    load_store_unit_if.slave req,
    output logic             MemWrite,
    output logic             MemRead,
    output logic             one_byte,
    output logic             two_byte,
    output logic             four_bytes,
    output logic             unsigned_load,
    output logic [DEPTH-1:0] Address,
    output logic [WIDTH-1:0] WriteData,
    input  logic [WIDTH-1:0] ReadData
);
    typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, RESP} state_t;

    state_t           state;
    logic             is_store;
    logic [WIDTH-1:0] eff;
    logic             legal, sz_b, sz_h, sz_w, uns, range_err, align_err;

    // Decode is evaluated only in IDLE against the live request inputs.
    always_comb begin
        eff   = req.base_addr + req.offset;
        legal = 1'b1;
        sz_b  = 1'b0;
        sz_h  = 1'b0;
        sz_w  = 1'b0;
        uns   = 1'b0;
        case (req.req_funct3)
            3'b000: sz_b = 1'b1;
            3'b001: sz_h = 1'b1;
            3'b010: sz_w = 1'b1;
            3'b100: begin sz_b = 1'b1; uns = 1'b1; legal = !req.req_store; end
            3'b101: begin sz_h = 1'b1; uns = 1'b1; legal = !req.req_store; end
            default: legal = 1'b0;
        endcase
        range_err = |eff[WIDTH-1:DEPTH];
        align_err = (sz_h & eff[0]) | (sz_w & (|eff[1:0]));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            is_store        <= 1'b0;
            req.req_ready   <= 1'b1;
            req.done        <= 1'b0;
            req.misaligned  <= 1'b0;
            req.fault       <= 1'b0;
            req.load_result <= '0;
            MemWrite        <= 1'b0;
            MemRead         <= 1'b0;
            one_byte        <= 1'b0;
            two_byte        <= 1'b0;
            four_bytes      <= 1'b0;
            unsigned_load   <= 1'b0;
            Address         <= '0;
            WriteData       <= '0;
        end else begin
            case (state)
                IDLE: if (req.req_valid) begin
                    req.req_ready <= 1'b0;
                    is_store      <= req.req_store;
                    if (!legal || range_err) begin
                        req.fault <= 1'b1;
                        req.done  <= 1'b1;
                        state     <= RESP;
                    end else if (align_err) begin
                        req.misaligned <= 1'b1;
                        req.done       <= 1'b1;
                        state          <= RESP;
                    end else begin
                        // Memory outputs are registered here so they are stable
                        // for the whole ACCESS (and CAPTURE) window.
                        Address       <= eff[DEPTH-1:0];
                        WriteData     <= req.store_data;
                        MemWrite      <= req.req_store;
                        MemRead       <= !req.req_store;
                        one_byte      <= sz_b;
                        two_byte      <= sz_h;
                        four_bytes    <= sz_w;
                        unsigned_load <= uns & !req.req_store;
                        state         <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (is_store) begin
                        MemWrite   <= 1'b0;
                        one_byte   <= 1'b0;
                        two_byte   <= 1'b0;
                        four_bytes <= 1'b0;
                        req.done   <= 1'b1;
                        state      <= RESP;
                    end else begin
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    req.load_result <= ReadData;
                    MemRead         <= 1'b0;
                    one_byte        <= 1'b0;
                    two_byte        <= 1'b0;
                    four_bytes      <= 1'b0;
                    unsigned_load   <= 1'b0;
                    req.done        <= 1'b1;
                    state           <= RESP;
                end
                RESP: begin
                    req.done       <= 1'b0;
                    req.misaligned <= 1'b0;
                    req.fault      <= 1'b0;
                    req.req_ready  <= 1'b1;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator side of the data-memory interface in the multicycle RISC-V core. Accepts one load/store request per transaction from the multicycle control FSM, computes the effective address, checks size/alignment/range, drives the `DataMemory` control and data ports, and returns the load result. Sign/zero extension and byte-lane placement remain inside `DataMemory`. This block only selects size and signedness and sequences the access.

## Interface
- `WIDTH`, 32: data width in bits
- `DEPTH`, 12: memory address bits (byte-addressed, 2^DEPTH bytes)

- `clk`  in  1  system clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `req_valid`  in  1  request present
- `req_ready`  out  1  block can accept a request; high only in IDLE
- `req_store`  in  1  1 = store, 0 = load
- `req_funct3`  in  3  RISC-V funct3 for the load/store
- `base_addr`  in  WIDTH  rs1 value
- `offset`  in  WIDTH  sign-extended immediate
- `store_data`  in  WIDTH  rs2 value
- `done`  out  1  one-cycle completion pulse
- `misaligned`  out  1  valid with `done`: alignment error, no access made
- `fault`  out  1  valid with `done`: illegal funct3 or out-of-range address, no access made
- `load_result`  out  WIDTH  registered `ReadData` from the last successful load
- `MemWrite`, `MemRead`  out  1 each  memory strobes
- `one_byte`, `two_byte`, `four_bytes`, `unsigned_load`  out  1 each  size/sign selects
- `Address`  out  DEPTH  byte address
- `WriteData`  out  WIDTH  store data
- `ReadData`  in  WIDTH  memory read data

## Operation
- The request is accepted on a rising edge with `req_valid & req_ready`. The block latches `eff = base_addr + offset` (WIDTH-bit, wrap discarded), plus funct3, store flag and store_data. Later input changes are ignored.
- Decode for loads:
  - 000 LB: one_byte, signed
  - 001 LH: two_byte, signed
  - 010 LW: four_bytes
  - 100 LBU: one_byte, unsigned
  - 101 LHU: two_byte, unsigned
  - 011, 110, 111: illegal
- Decode for stores:
  - 000 SB, 001 SH, 010 SW
  - any other funct3: illegal
- Error priority is illegal funct3, then range, then alignment.
  - Range fault: any bit `eff[WIDTH-1:DEPTH]` set.
  - Misaligned: halfword with `eff[0]` set, or word with `eff[1:0]` nonzero.
  - Bytes are never misaligned.
- States:
  - IDLE: `req_ready`=1. On accept, go to RESP if an error is detected, else to ACCESS.
  - ACCESS: drive `Address=eff[DEPTH-1:0]`, `WriteData=store_data` unshifted, size selects, and `unsigned_load` (0 for stores and LW). Assert `MemWrite` for a store or `MemRead` for a load. A store goes to RESP, a load goes to CAPTURE.
  - CAPTURE: hold all memory outputs including `MemRead`. Register `load_result <= ReadData` at the edge leaving this state, then go to RESP.
  - RESP: `done`=1 with `misaligned`/`fault`, then return to IDLE.
- Outside ACCESS/CAPTURE:
  - `MemWrite`, `MemRead`, all size selects and `unsigned_load` are 0.
  - `Address` and `WriteData` hold their last value.
- `load_result` changes only on a successful load. Stores and errors leave it unchanged.

## Timing
- Reset values:
  - state IDLE, `req_ready`=1
  - `done`, `misaligned`, `fault`, `MemWrite`, `MemRead`, `one_byte`, `two_byte`, `four_bytes`, `unsigned_load` = 0
  - `Address`=0, `WriteData`=0, `load_result`=0
- Latency after the accept edge (cycle 1 is the first cycle after acceptance):
  - Store: ACCESS in cycle 1, `done` in cycle 2.
  - Load: ACCESS in cycle 1, CAPTURE in cycle 2, `done` in cycle 3, `load_result` valid from cycle 3.
  - Error: `done` in cycle 1, zero memory strobes.
- `MemWrite` is high for exactly one cycle per store. `MemRead` is high for exactly two cycles per load.
- `req_ready`=0 from the accept edge until the cycle after `done`. `req_valid` during that time is ignored, not queued.
- Back-to-back: a request presented in the IDLE cycle that follows RESP is accepted. Throughput is one store per 3 cycles and one load per 4 cycles.
- Reset asserted mid-transaction: all strobes drop immediately (asynchronously) and no `done` is issued. A store in ACCESS may or may not have committed.

## Test plan
- SW 0xDEADBEEF at base 0, offset 0 -> one `MemWrite` cycle, `done` at +2. Then LW at 0 -> `done` at +3, `load_result`=0xDEADBEEF, `four_bytes`=1 during access.
- SB 0x000000FF at address 4 -> LB at 4 gives 0xFFFFFFFF; LBU at 4 gives 0x000000FF, with `unsigned_load`=1 only for LBU.
- SW 0x12345678 at 12 -> LHU at base 10 offset 2 gives 0x00005678; LBU at 13 gives 0x00000056 (base+offset addition checked).
- LH at 0x009, LW at 0x00E -> each gives `done` at +1 with `misaligned`=1, `MemRead` never high, `load_result` unchanged.
- LW at 0x1000 (`fault`=1) and funct3=011 (`fault`=1) -> no strobes. A second `req_valid` while busy is ignored (`req_ready`=0).
- Assert `rst` during CAPTURE of a load -> strobes 0 immediately, no `done`, `load_result`=0, `req_ready`=1 after release, and the next request completes normally.
